// File: rtl/fetch_squash_redirect.sv
// rtl/fetch_squash_redirect.sv - fetch PC generation, imem requests and squash redirect with stale-response drop
// Optional FETCH_SQUASH_STATS_EN adds redirect/drop statistics counters.
module fetch_squash_redirect #(
  parameter logic [31:0] p_rst_addr      = 32'h200,
  parameter int          p_max_in_flight = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        squash_val,
  input  logic [31:0] squash_target,
  output logic        mem_req_val,
  input  logic        mem_req_rdy,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_val,
  output logic        mem_resp_rdy,
  input  logic [31:0] mem_resp_data,
  output logic        dec_val,
  input  logic        dec_rdy,
  output logic [31:0] dec_pc,
`ifdef FETCH_SQUASH_STATS_EN
  output logic [31:0] dec_inst,
  output logic [31:0] stat_redirects,
  output logic [31:0] stat_drops
`else
  output logic [31:0] dec_inst
`endif
);

  localparam int CW = $clog2(p_max_in_flight + 1);
  localparam int PW = (p_max_in_flight > 1) ? $clog2(p_max_in_flight) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(p_max_in_flight);
  localparam logic [PW-1:0] LAST_PTR = PW'(p_max_in_flight - 1);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fifo_q [p_max_in_flight];
  logic [31:0]   fifo_d [p_max_in_flight];

  logic dropping;
  logic req_xfer;
  logic resp_xfer;

  always_comb begin
    // A squash makes the response of its own cycle stale as well.
    dropping     = (drop_cnt_q != '0) || squash_val;
    mem_req_val  = !rst && (in_flight_q < MAX_CNT);
    mem_req_addr = squash_val ? squash_target : pc_q;
    mem_resp_rdy = !rst && (dropping || dec_rdy);
    dec_val      = !rst && !dropping && mem_resp_val;
    dec_pc       = fifo_q[rd_ptr_q];
    dec_inst     = mem_resp_data;
    req_xfer     = mem_req_val && mem_req_rdy;
    resp_xfer    = mem_resp_val && mem_resp_rdy;
  end

  always_comb begin
    pc_d        = pc_q;
    in_flight_d = in_flight_q;
    drop_cnt_d  = drop_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_d      = fifo_q;

    if (req_xfer) begin
      pc_d             = mem_req_addr + 32'd4;
      fifo_d[wr_ptr_q] = mem_req_addr;
      wr_ptr_d         = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end else if (squash_val) begin
      pc_d = squash_target;
    end

    if (resp_xfer) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end

    if (req_xfer && !resp_xfer) begin
      in_flight_d = in_flight_q + 1'b1;
    end else if (!req_xfer && resp_xfer) begin
      in_flight_d = in_flight_q - 1'b1;
    end

    // Recomputed (not accumulated) so a second squash covers every older response.
    if (squash_val) begin
      drop_cnt_d = in_flight_q - CW'(mem_resp_val);
    end else if ((drop_cnt_q != '0) && resp_xfer) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= p_rst_addr;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < p_max_in_flight; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_q      <= fifo_d;
    end
  end

`ifdef FETCH_SQUASH_STATS_EN
  logic [31:0] stat_redirects_q, stat_redirects_d;
  logic [31:0] stat_drops_q, stat_drops_d;

  always_comb begin
    stat_redirects_d = stat_redirects_q + 32'(squash_val);
    stat_drops_d     = stat_drops_q + 32'(resp_xfer && dropping);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_redirects_q <= '0;
      stat_drops_q     <= '0;
    end else begin
      stat_redirects_q <= stat_redirects_d;
      stat_drops_q     <= stat_drops_d;
    end
  end

  assign stat_redirects = stat_redirects_q;
  assign stat_drops     = stat_drops_q;
`endif

endmodule

// File: tb/tb_fetch_squash_redirect.sv
// tb/tb_fetch_squash_redirect.sv - bench for fetch_squash_redirect with an in-order imem responder
// Builds with or without FETCH_SQUASH_STATS_EN.
module tb_fetch_squash_redirect;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        squash_val;
  logic [31:0] squash_target;
  logic        mem_req_val;
  logic        mem_req_rdy;
  logic [31:0] mem_req_addr;
  logic        mem_resp_val;
  logic        mem_resp_rdy;
  logic [31:0] mem_resp_data;
  logic        dec_val;
  logic        dec_rdy;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
`ifdef FETCH_SQUASH_STATS_EN
  logic [31:0] stat_redirects;
  logic [31:0] stat_drops;
`endif

  fetch_squash_redirect #(.p_rst_addr(32'h200), .p_max_in_flight(MAX)) dut (
    .clk           (clk),
    .rst           (rst),
    .squash_val    (squash_val),
    .squash_target (squash_target),
    .mem_req_val   (mem_req_val),
    .mem_req_rdy   (mem_req_rdy),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_val  (mem_resp_val),
    .mem_resp_rdy  (mem_resp_rdy),
    .mem_resp_data (mem_resp_data),
    .dec_val       (dec_val),
    .dec_rdy       (dec_rdy),
    .dec_pc        (dec_pc),
`ifdef FETCH_SQUASH_STATS_EN
    .dec_inst      (dec_inst),
    .stat_redirects(stat_redirects),
    .stat_drops    (stat_drops)
`else
    .dec_inst      (dec_inst)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } ent_t;

  ent_t        pend[$];
  logic [31:0] imem_q[$];
  logic [31:0] dec_log[$];
  logic [31:0] m_pc;
  logic [31:0] m_redir;
  logic [31:0] m_drops;
  bit          resp_en;
  int          vectors;
  int          miscompares;

  bit          e_req;
  bit          e_drop;
  bit          e_rdy;
  bit          e_dval;
  logic [31:0] e_addr;

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] log_at(int i);
    if (i < dec_log.size()) return dec_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is at the drive point; holds the squash for exactly one cycle.
  task automatic squash(logic [31:0] t);
    squash_val    = 1'b1;
    squash_target = t;
    #2;
    check("squash_req_addr", mem_req_addr, t);
    check("squash_dec_val", 32'(dec_val), 32'd0);
    check("squash_resp_rdy", 32'(mem_resp_rdy), 32'd1);
    cyc(1);
    squash_val = 1'b0;
  endtask

  // In-order imem with one-cycle latency; driven after the stimulus settles.
  always @(posedge clk) begin
    #2;
    if (!rst && resp_en && imem_q.size() > 0) begin
      mem_resp_val  = 1'b1;
      mem_resp_data = inst_of(imem_q[0]);
    end else begin
      mem_resp_val  = 1'b0;
      mem_resp_data = 32'd0;
    end
  end

  // Model: queue of outstanding PCs; a squash marks every outstanding one stale.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_req_val", 32'(mem_req_val), 32'd0);
      check("rst_resp_rdy", 32'(mem_resp_rdy), 32'd0);
      check("rst_dec_val", 32'(dec_val), 32'd0);
      pend.delete();
      imem_q.delete();
      m_pc    = 32'h200;
      m_redir = 32'd0;
      m_drops = 32'd0;
    end else begin
      e_req  = pend.size() < MAX;
      e_addr = squash_val ? squash_target : m_pc;
      e_drop = squash_val || (pend.size() > 0 && pend[0].stale);
      e_rdy  = e_drop || dec_rdy;
      e_dval = !e_drop && mem_resp_val;
      check("req_val", 32'(mem_req_val), 32'(e_req));
      check("resp_rdy", 32'(mem_resp_rdy), 32'(e_rdy));
      check("dec_val", 32'(dec_val), 32'(e_dval));
      if (e_req) check("req_addr", mem_req_addr, e_addr);
      if (e_dval && pend.size() > 0) begin
        check("dec_pc", dec_pc, pend[0].pc);
        check("dec_inst", dec_inst, inst_of(pend[0].pc));
      end
`ifdef FETCH_SQUASH_STATS_EN
      check("stat_redirects", stat_redirects, m_redir);
      check("stat_drops", stat_drops, m_drops);
`endif
      if (mem_resp_val && e_rdy && pend.size() > 0) begin
        if (e_drop) m_drops = m_drops + 32'd1;
        void'(pend.pop_front());
      end
      if (squash_val) begin
        m_redir = m_redir + 32'd1;
        for (int i = 0; i < pend.size(); i++) begin
          ent_t e;
          e       = pend[i];
          e.stale = 1'b1;
          pend[i] = e;
        end
      end
      if (e_req && mem_req_rdy) begin
        pend.push_back('{e_addr, 1'b0});
        m_pc = e_addr + 32'd4;
      end else if (squash_val) begin
        m_pc = squash_target;
      end
      if (mem_resp_val && mem_resp_rdy && imem_q.size() > 0) void'(imem_q.pop_front());
      if (mem_req_val && mem_req_rdy) imem_q.push_back(mem_req_addr);
      if (dec_val && dec_rdy) dec_log.push_back(dec_pc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int          mark;
    logic [31:0] last;
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    squash_val    = 1'b0;
    squash_target = 32'd0;
    mem_req_rdy   = 1'b1;
    dec_rdy       = 1'b1;
    resp_en       = 1'b1;
    mem_resp_val  = 1'b0;
    mem_resp_data = 32'd0;
    cyc(3);
    check("lit_rst_req_val", 32'(mem_req_val), 32'd0);
    rst = 1'b0;
    #1;
    check("lit_first_addr", mem_req_addr, 32'h200);

    // Sequential fetch
    cyc(6);
    check("lit_seq0", log_at(0), 32'h200);
    check("lit_seq1", log_at(1), 32'h204);
    check("lit_seq2", log_at(2), 32'h208);

    // Squash with two responses outstanding
    resp_en = 1'b0;
    cyc(3);
    check("lit_full_req_val", 32'(mem_req_val), 32'd0);
    mark = dec_log.size();
    squash(32'h1000);
    resp_en = 1'b1;
    cyc(6);
    check("lit_sq1_first", log_at(mark), 32'h1000);
    check("lit_sq1_second", log_at(mark + 1), 32'h1004);

    // Second squash while still dropping
    resp_en = 1'b0;
    cyc(3);
    mark = dec_log.size();
    squash(32'h1000);
    resp_en = 1'b1;
    cyc(1);
    resp_en = 1'b0;
    squash(32'h2000);
    resp_en = 1'b1;
    cyc(6);
    check("lit_sq2_first", log_at(mark), 32'h2000);
    check("lit_sq2_second", log_at(mark + 1), 32'h2004);

    // Squash coinciding with a response
    cyc(4);
    mark = dec_log.size();
    squash(32'h3000);
    cyc(4);
    check("lit_sq3_first", log_at(mark), 32'h3000);
    check("lit_sq3_second", log_at(mark + 1), 32'h3004);

    // Decode backpressure
    dec_rdy = 1'b0;
    cyc(10);
    check("lit_bp_req_val", 32'(mem_req_val), 32'd0);
    last = dec_log[dec_log.size() - 1];
    mark = dec_log.size();
    dec_rdy = 1'b1;
    cyc(4);
    check("lit_bp_resume0", log_at(mark), last + 32'd4);
    check("lit_bp_resume1", log_at(mark + 1), last + 32'd8);

    // Squash with no request accepted: pc takes the target directly
    mem_req_rdy = 1'b0;
    cyc(3);
    mark = dec_log.size();
    squash(32'h4000);
    mem_req_rdy = 1'b1;
    cyc(4);
    check("lit_sq4_first", log_at(mark), 32'h4000);

    // Two squashes dropping three responses, then reset mid-stream
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    resp_en = 1'b0;
    cyc(3);
    squash(32'h1000);
    resp_en = 1'b1;
    cyc(4);
    squash(32'h3000);
`ifdef FETCH_SQUASH_STATS_EN
    check("lit_stat_redirects", stat_redirects, 32'd2);
    check("lit_stat_drops", stat_drops, 32'd3);
`endif
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    #1;
    check("lit_rst_mid_addr", mem_req_addr, 32'h200);
    check("lit_rst_mid_req_val", 32'(mem_req_val), 32'd1);
`ifdef FETCH_SQUASH_STATS_EN
    check("lit_rst_stat_redirects", stat_redirects, 32'd0);
    check("lit_rst_stat_drops", stat_drops, 32'd0);
`endif
    cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
